// File: rtl/mmio_fabric_pkg.sv
// Shared types for the MMIO bus fabric:
// FSM states, target kinds, control offsets and address decode.
package mmio_fabric_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESPOND
  } state_t;

  typedef enum logic [1:0] {
    T_MEM,
    T_PERIPH,
    T_CTRL
  } tgt_t;

  localparam logic [1:0] R_PERIPH      = 2'b01;
  localparam logic [1:0] OFS_TX_SEL    = 2'd0;
  localparam logic [1:0] OFS_ERR_COUNT = 2'd1;
  localparam logic [1:0] OFS_LAST_ERR  = 2'd2;

  typedef struct packed {
    tgt_t       kind;
    logic [7:0] idx;
    logic       valid;
  } dec_t;

  function automatic dec_t decode(
    input logic [63:0] addr,
    input int          sel_lsb,
    input int          sel_bits,
    input int          num_periph
  );
    logic [63:0] sh;
    logic [1:0]  region;
    dec_t        d;
    sh      = addr >> sel_lsb;
    region  = 2'(sh >> sel_bits);
    d.idx   = 8'(sh & ((64'd1 << sel_bits) - 64'd1));
    d.valid = 1'b1;
    if (region[1]) begin
      d.kind = T_CTRL;
    end else if (region == R_PERIPH) begin
      d.kind  = T_PERIPH;
      d.valid = {24'd0, d.idx} < 32'(num_periph);
    end else begin
      d.kind = T_MEM;
    end
    return d;
  endfunction

endpackage

// File: rtl/mmio_ctrl_regs.sv
// Fabric control registers: serial output select,
// saturating bus error counter and last error address.
module mmio_ctrl_regs
  import mmio_fabric_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_PERIPH = 4,
  parameter int SEL_BITS   = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic [1:0]            offset,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  err,
  input  logic [ADDR_WIDTH-1:0] err_addr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [SEL_BITS-1:0]   tx_sel
);

  logic [7:0]            err_count;
  logic [ADDR_WIDTH-1:0] last_err;

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_sel    <= '0;
      err_count <= '0;
      last_err  <= '0;
    end else begin
      if (we && offset == OFS_TX_SEL &&
          wdata < DATA_WIDTH'(NUM_PERIPH))
        tx_sel <= wdata[SEL_BITS-1:0];
      // a software clear beats a same-cycle error bump
      if (we && offset == OFS_ERR_COUNT)
        err_count <= '0;
      else if (err && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
      if (err)
        last_err <= err_addr;
    end
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      (offset == OFS_TX_SEL):    rdata = DATA_WIDTH'(tx_sel);
      (offset == OFS_ERR_COUNT): rdata = DATA_WIDTH'(err_count);
      (offset == OFS_LAST_ERR):  rdata = DATA_WIDTH'(last_err);
      default: ;
    endcase
  end

endmodule

// File: rtl/mmio_bus_fabric.sv
// Memory-mapped interconnect: CPU data port to data memory,
// NUM_PERIPH peripherals and local control registers.
module mmio_bus_fabric
  import mmio_fabric_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int NUM_PERIPH     = 4,
  parameter int SEL_LSB        = 8,
  parameter int SEL_BITS       = 2,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             cpu_read,
  input  logic                             cpu_write,
  input  logic [ADDR_WIDTH-1:0]            cpu_address,
  input  logic [DATA_WIDTH-1:0]            cpu_write_data,
  output logic [DATA_WIDTH-1:0]            cpu_read_data,
  output logic                             cpu_ready,
  output logic                             cpu_error,
  output logic [ADDR_WIDTH-1:0]            tgt_address,
  output logic [DATA_WIDTH-1:0]            tgt_write_data,
  output logic                             mem_read,
  output logic                             mem_write,
  input  logic [DATA_WIDTH-1:0]            mem_read_data,
  input  logic                             mem_ready,
  output logic [NUM_PERIPH-1:0]            periph_read,
  output logic [NUM_PERIPH-1:0]            periph_write,
  input  logic [NUM_PERIPH*DATA_WIDTH-1:0] periph_read_data,
  input  logic [NUM_PERIPH-1:0]            periph_ready,
  input  logic [NUM_PERIPH-1:0]            periph_tx,
  output logic                             tx_out
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t                state;
  tgt_t                  kind_q;
  logic [7:0]            idx_q;
  logic                  op_rd;
  logic                  op_wr;
  logic [CW-1:0]         wait_cnt;
  dec_t                  dec;
  logic                  sel_ready;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic [DATA_WIDTH-1:0] ctrl_rdata;
  logic [SEL_BITS-1:0]   tx_sel;
  logic                  ctrl_we;
  logic                  err_pulse;

  assign dec = decode(64'(cpu_address), SEL_LSB,
                      SEL_BITS, NUM_PERIPH);

  assign ctrl_we = state == S_ACCESS &&
                   kind_q == T_CTRL && op_wr;
  assign err_pulse = state == S_RESPOND && cpu_error;

  mmio_ctrl_regs #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_PERIPH (NUM_PERIPH),
    .SEL_BITS   (SEL_BITS)
  ) u_ctrl (
    .clock    (clock),
    .reset    (reset),
    .we       (ctrl_we),
    .offset   (tgt_address[3:2]),
    .wdata    (tgt_write_data),
    .err      (err_pulse),
    .err_addr (tgt_address),
    .rdata    (ctrl_rdata),
    .tx_sel   (tx_sel)
  );

  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    unique case (kind_q)
      T_MEM: begin
        sel_ready = mem_ready;
        sel_rdata = mem_read_data;
      end
      T_PERIPH: begin
        for (int i = 0; i < NUM_PERIPH; i++)
          if (idx_q == 8'(i)) begin
            sel_ready = periph_ready[i];
            sel_rdata = periph_read_data[i*DATA_WIDTH +: DATA_WIDTH];
          end
      end
      T_CTRL: begin
        sel_ready = 1'b1;
        sel_rdata = ctrl_rdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    periph_read  = '0;
    periph_write = '0;
    if (state == S_ACCESS) begin
      mem_read  = kind_q == T_MEM && op_rd;
      mem_write = kind_q == T_MEM && op_wr;
      for (int i = 0; i < NUM_PERIPH; i++) begin
        periph_read[i]  = kind_q == T_PERIPH &&
                          idx_q == 8'(i) && op_rd;
        periph_write[i] = kind_q == T_PERIPH &&
                          idx_q == 8'(i) && op_wr;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      kind_q         <= T_MEM;
      idx_q          <= '0;
      op_rd          <= 1'b0;
      op_wr          <= 1'b0;
      wait_cnt       <= '0;
      tgt_address    <= '0;
      tgt_write_data <= '0;
      cpu_read_data  <= '0;
      cpu_ready      <= 1'b0;
      cpu_error      <= 1'b0;
    end else begin
      cpu_ready <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cpu_read || cpu_write) begin
            op_rd          <= cpu_read;
            op_wr          <= cpu_write;
            kind_q         <= dec.kind;
            idx_q          <= dec.idx;
            tgt_address    <= cpu_address;
            tgt_write_data <= cpu_write_data;
            wait_cnt       <= '0;
            // conflicting or unmapped requests never strobe a target
            if ((cpu_read && cpu_write) || !dec.valid) begin
              state         <= S_RESPOND;
              cpu_ready     <= 1'b1;
              cpu_error     <= 1'b1;
              cpu_read_data <= '1;
            end else begin
              state <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (sel_ready) begin
            state         <= S_RESPOND;
            cpu_ready     <= 1'b1;
            cpu_error     <= 1'b0;
            cpu_read_data <= op_rd ? sel_rdata : '0;
          end else if (wait_cnt == TMO_LAST) begin
            state         <= S_RESPOND;
            cpu_ready     <= 1'b1;
            cpu_error     <= 1'b1;
            cpu_read_data <= '1;
          end
        end
        S_RESPOND: begin
          state     <= S_IDLE;
          cpu_error <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) tx_out <= 1'b1;
    else       tx_out <= periph_tx[tx_sel];
  end

endmodule

// File: tb/tb_mmio_bus_fabric.sv
// Directed scoreboard bench for mmio_bus_fabric
// (4-peripheral instance plus a 3-peripheral one for unmapped decode).
module tb_mmio_bus_fabric;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_read = 1'b0;
  logic        cpu_write = 1'b0;
  logic [31:0] cpu_address = '0;
  logic [31:0] cpu_write_data = '0;
  logic [31:0] cpu_read_data;
  logic        cpu_ready;
  logic        cpu_error;
  logic [31:0] tgt_address;
  logic [31:0] tgt_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_read_data;
  logic        mem_ready;
  logic [3:0]  periph_read;
  logic [3:0]  periph_write;
  logic [127:0] periph_read_data;
  logic [3:0]  periph_ready;
  logic [3:0]  periph_tx = 4'b0000;
  logic        tx_out;

  logic        b_read = 1'b0;
  logic [31:0] b_address = '0;
  logic [31:0] b_rdata;
  logic        b_ready;
  logic        b_error;
  logic [31:0] b_taddr;
  logic [31:0] b_twdata;
  logic        b_mr;
  logic        b_mw;
  logic [2:0]  b_pr;
  logic [2:0]  b_pw;
  logic        b_tx;
  logic [7:0]  b_strobes;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int passes = 0;
  int fails = 0;
  int resp_waits = 0;
  int acc_cnt = 0;
  logic [9:0] strobes;

  always #5 clock = ~clock;

  mmio_bus_fabric dut (
    .clock            (clock),
    .reset            (reset),
    .cpu_read         (cpu_read),
    .cpu_write        (cpu_write),
    .cpu_address      (cpu_address),
    .cpu_write_data   (cpu_write_data),
    .cpu_read_data    (cpu_read_data),
    .cpu_ready        (cpu_ready),
    .cpu_error        (cpu_error),
    .tgt_address      (tgt_address),
    .tgt_write_data   (tgt_write_data),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_read_data    (mem_read_data),
    .mem_ready        (mem_ready),
    .periph_read      (periph_read),
    .periph_write     (periph_write),
    .periph_read_data (periph_read_data),
    .periph_ready     (periph_ready),
    .periph_tx        (periph_tx),
    .tx_out           (tx_out)
  );

  mmio_bus_fabric #(.NUM_PERIPH(3)) dut3 (
    .clock            (clock),
    .reset            (reset),
    .cpu_read         (b_read),
    .cpu_write        (1'b0),
    .cpu_address      (b_address),
    .cpu_write_data   (32'h0),
    .cpu_read_data    (b_rdata),
    .cpu_ready        (b_ready),
    .cpu_error        (b_error),
    .tgt_address      (b_taddr),
    .tgt_write_data   (b_twdata),
    .mem_read         (b_mr),
    .mem_write        (b_mw),
    .mem_read_data    (32'h0),
    .mem_ready        (1'b0),
    .periph_read      (b_pr),
    .periph_write     (b_pw),
    .periph_read_data (96'h0),
    .periph_ready     (3'b000),
    .periph_tx        (3'b000),
    .tx_out           (b_tx)
  );

  assign b_strobes = {b_mr, b_mw, b_pr, b_pw};

  // target model: answer after resp_waits strobe cycles
  assign strobes = {mem_read, mem_write, periph_read, periph_write};
  always @(posedge clock) acc_cnt <= (|strobes) ? acc_cnt + 1 : 0;
  assign mem_ready = (mem_read | mem_write) && acc_cnt == resp_waits;
  always_comb
    for (int i = 0; i < 4; i++)
      periph_ready[i] = (periph_read[i] | periph_write[i]) &&
                        acc_cnt == resp_waits;
  assign mem_read_data = 32'hDEAD_0000;
  assign periph_read_data = {32'h41, 32'h40, 32'h3F, 32'h3E};

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic txn(input string tag, input logic rd, input logic wr,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input int waits, input logic [9:0] mask,
                     input int exp_hi, input logic exp_err,
                     input logic dchk, input logic [31:0] exp_data,
                     input int exp_lat);
    int k;
    int hi;
    int bad;
    exp_t e;
    @(negedge clock);
    resp_waits = waits;
    cpu_read = rd;
    cpu_write = wr;
    cpu_address = addr;
    cpu_write_data = wdata;
    sb.push_back('{exp_err, exp_data, exp_lat});
    k = 0;
    hi = 0;
    bad = 0;
    do begin
      @(negedge clock);
      k++;
      if (|(strobes & mask)) hi++;
      if (|(strobes & ~mask)) bad++;
    end while (!cpu_ready && k < 40);
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    e = sb.pop_front();
    chk({tag, ".ready"}, 64'(cpu_ready), 64'd1);
    chk({tag, ".err"}, 64'(cpu_error), 64'(e.err));
    if (dchk) chk({tag, ".data"}, 64'(cpu_read_data), 64'(e.data));
    chk({tag, ".lat"}, 64'(k), 64'(e.lat));
    chk({tag, ".strobe"}, 64'(hi), 64'(exp_hi));
    chk({tag, ".stray"}, 64'(bad), 64'd0);
    @(negedge clock);
    chk({tag, ".pulse"}, 64'(cpu_ready), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [7:0] seen;

    repeat (3) @(negedge clock);
    chk("rst.ready", 64'(cpu_ready), 64'd0);
    chk("rst.err", 64'(cpu_error), 64'd0);
    chk("rst.strobes", 64'(strobes), 64'd0);
    chk("rst.tx", 64'(tx_out), 64'd1);
    chk("rst.rdata", 64'(cpu_read_data), 64'd0);
    chk("rst.taddr", 64'(tgt_address), 64'd0);
    chk("rst.twdata", 64'(tgt_write_data), 64'd0);
    reset = 1'b0;

    @(negedge clock);
    b_read = 1'b1;
    b_address = 32'h0000_0700;
    k = 0;
    seen = '0;
    do begin
      @(negedge clock);
      k++;
      seen |= b_strobes;
    end while (!b_ready && k < 10);
    b_read = 1'b0;
    chk("unmap.ready", 64'(b_ready), 64'd1);
    chk("unmap.err", 64'(b_error), 64'd1);
    chk("unmap.lat", 64'(k), 64'd1);
    chk("unmap.strobe", 64'(seen), 64'd0);
    chk("unmap.taddr", 64'(b_taddr), 64'h700);
    chk("unmap.tx", 64'(b_tx), 64'd0);

    txn("mw", 0, 1, 32'h010, 32'hA5A5_0001, 0, 10'h100, 1,
        0, 1, 32'h0, 2);
    chk("mw.taddr", 64'(tgt_address), 64'h010);
    chk("mw.twdata", 64'(tgt_write_data), 64'hA5A5_0001);
    txn("mr", 1, 0, 32'h020, 32'h0, 2, 10'h200, 3,
        0, 1, 32'hDEAD_0000, 4);
    txn("pr3", 1, 0, 32'h700, 32'h0, 3, 10'h080, 4,
        0, 1, 32'h41, 5);
    txn("tmo", 1, 0, 32'h400, 32'h0, 99, 10'h010, 15,
        1, 1, 32'hFFFF_FFFF, 16);
    txn("errcnt1", 1, 0, 32'h804, 32'h0, 0, 10'h0, 0,
        0, 1, 32'd1, 2);
    txn("lasterr", 1, 0, 32'h808, 32'h0, 0, 10'h0, 0,
        0, 1, 32'h400, 2);

    txn("txsel2", 0, 1, 32'h800, 32'd2, 0, 10'h0, 0,
        0, 1, 32'h0, 2);
    periph_tx = 4'b0100;
    repeat (2) @(negedge clock);
    chk("tx.sel2hi", 64'(tx_out), 64'd1);
    periph_tx = 4'b1011;
    repeat (2) @(negedge clock);
    chk("tx.sel2lo", 64'(tx_out), 64'd0);
    txn("txsel7", 0, 1, 32'h800, 32'd7, 0, 10'h0, 0,
        0, 1, 32'h0, 2);
    repeat (2) @(negedge clock);
    chk("tx.hold", 64'(tx_out), 64'd0);
    txn("txselrd", 1, 0, 32'h800, 32'h0, 0, 10'h0, 0,
        0, 1, 32'd2, 2);

    txn("conflict", 1, 1, 32'h010, 32'h5, 0, 10'h0, 0,
        1, 0, 32'h0, 1);
    txn("errcnt2", 1, 0, 32'h804, 32'h0, 0, 10'h0, 0,
        0, 1, 32'd2, 2);
    txn("lasterr2", 1, 0, 32'h808, 32'h0, 0, 10'h0, 0,
        0, 1, 32'h010, 2);
    txn("errclr", 0, 1, 32'h804, 32'h0, 0, 10'h0, 0,
        0, 1, 32'h0, 2);
    txn("errcnt0", 1, 0, 32'h804, 32'h0, 0, 10'h0, 0,
        0, 1, 32'd0, 2);
    for (int i = 0; i < 256; i++)
      txn("sat", 1, 1, 32'h010, 32'h0, 0, 10'h0, 0,
          1, 0, 32'h0, 1);
    txn("errsat", 1, 0, 32'h804, 32'h0, 0, 10'h0, 0,
        0, 1, 32'd255, 2);

    @(negedge clock);
    resp_waits = 99;
    cpu_read = 1'b1;
    cpu_address = 32'h400;
    repeat (3) @(negedge clock);
    chk("rma.strobe", 64'(periph_read[0]), 64'd1);
    chk("rma.txpre", 64'(tx_out), 64'd0);
    reset = 1'b1;
    cpu_read = 1'b0;
    @(negedge clock);
    chk("rma.nostrobe", 64'(strobes), 64'd0);
    chk("rma.noready", 64'(cpu_ready), 64'd0);
    chk("rma.tx", 64'(tx_out), 64'd1);
    repeat (2) @(negedge clock);
    chk("rma.noready2", 64'(cpu_ready), 64'd0);
    reset = 1'b0;
    txn("rma.txsel", 1, 0, 32'h800, 32'h0, 0, 10'h0, 0,
        0, 1, 32'd0, 2);
    txn("rma.errcnt", 1, 0, 32'h804, 32'h0, 0, 10'h0, 0,
        0, 1, 32'd0, 2);
    chk("sb.empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
